// File: rtl/adder_accumulator.sv
// adder_accumulator: collects N_OPS unsigned operands over a valid/ready
// input handshake and sums them into an ACC_W-bit accumulator. The batch sum
// and a sticky carry-out flag are then offered on a valid/ready output
// handshake.
// Optional build macro: ADDER_ACC_SATURATE_EN. When it is defined, a carry
// out of the accumulator clamps acc to all ones for the rest of the batch.
// When it is undefined, the sum wraps modulo 2^ACC_W.
//
// state | meaning
// IDLE  | waiting for the first operand of a batch; acc/cnt/ovf are zero
// ACCUM | batch in progress; cnt operands have been summed so far
// DONE  | result presented on out_*; input is stalled until it is consumed
module adder_accumulator #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 6,
    parameter int N_OPS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    localparam int CNT_W = $clog2(N_OPS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_OPS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic [ACC_W-1:0] acc_base;
    logic             ovf_base;
    logic [CNT_W-1:0] cnt_base;
    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic [ACC_W-1:0] acc_next;
    logic             ovf_next;
    logic [CNT_W-1:0] cnt_next;
    logic             beat_last;

    // Input is open whenever no result is waiting; depends on state only.
    assign in_ready = (state != DONE);

    // Next accumulator values for an accepted beat. IDLE uses a zero base, so
    // the first beat loads the operand and restarts ovf/cnt.
    always_comb begin
        acc_base  = (state == IDLE) ? '0   : acc;
        ovf_base  = (state == IDLE) ? 1'b0 : ovf;
        cnt_base  = (state == IDLE) ? '0   : cnt;
        sum_ext   = {1'b0, acc_base} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};
        carry     = sum_ext[ACC_W];
        ovf_next  = ovf_base | carry;
`ifdef ADDER_ACC_SATURATE_EN
        acc_next  = ovf_next ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
        acc_next  = sum_ext[ACC_W-1:0];
`endif
        cnt_next  = cnt_base + CNT_ONE;
        beat_last = (cnt_next == CNT_LAST);
    end

    // Batch sequencer. clr aborts the batch and wins over either handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (in_valid) begin
                        acc <= acc_next;
                        ovf <= ovf_next;
                        cnt <= cnt_next;
                        if (beat_last) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_sum   <= acc_next;
                            out_ovf   <= ovf_next;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        acc       <= '0;
                        cnt       <= '0;
                        ovf       <= 1'b0;
                        out_valid <= 1'b0;
                        out_sum   <= '0;
                        out_ovf   <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    acc       <= '0;
                    cnt       <= '0;
                    ovf       <= 1'b0;
                    out_valid <= 1'b0;
                    out_sum   <= '0;
                    out_ovf   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_accumulator.sv
// Directed bench for adder_accumulator. Two instances share the stimulus:
// the default 6-bit accumulator, and a 5-bit one that overflows on larger
// batches.
module tb_adder_accumulator;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic [3:0] in_data;
    logic       out_ready;
    logic       in_ready;
    logic       out_valid;
    logic [5:0] out_sum;
    logic       out_ovf;
    logic       in_ready5;
    logic       out_valid5;
    logic [4:0] out_sum5;
    logic       out_ovf5;

    int checks;
    int failures;

`ifdef ADDER_ACC_SATURATE_EN
    localparam int SUM5_T2 = 31;
    localparam int SUM5_T6 = 31;
`else
    localparam int SUM5_T2 = 28;
    localparam int SUM5_T6 = 0;
`endif

    adder_accumulator #(.DATA_W(4), .ACC_W(6), .N_OPS(4)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf)
    );

    adder_accumulator #(.DATA_W(4), .ACC_W(5), .N_OPS(4)) dut5 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready5), .in_data(in_data),
        .out_valid(out_valid5), .out_ready(out_ready),
        .out_sum(out_sum5), .out_ovf(out_ovf5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = 4'hF;
    endtask

    task automatic chk_result(input string tag, input int s6, input int o6,
                              input int s5, input int o5);
        chk({tag, "_valid"},  32'(out_valid),  1);
        chk({tag, "_sum"},    32'(out_sum),    32'(s6));
        chk({tag, "_ovf"},    32'(out_ovf),    32'(o6));
        chk({tag, "_valid5"}, 32'(out_valid5), 1);
        chk({tag, "_sum5"},   32'(out_sum5),   32'(s5));
        chk({tag, "_ovf5"},   32'(out_ovf5),   32'(o5));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        out_ready = 1'b1;
        #23;
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_in_ready",  32'(in_ready),  1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_sum",   32'(out_sum),   0);
        chk("rst_out_ovf",   32'(out_ovf),   0);

        // 1: 3,5,7,1 back-to-back with out_ready high
        send(4'd3); send(4'd5); send(4'd7);
        chk("t1_no_early_valid", 32'(out_valid), 0);
        send(4'd1);
        chk_result("t1", 16, 0, 16, 0);
        chk("t1_in_ready_done", 32'(in_ready), 0);
        tick();
        chk("t1_valid_one_cycle", 32'(out_valid), 0);
        chk("t1_in_ready_again",  32'(in_ready),  1);

        // 2: four 15s; 5-bit instance overflows
        send(4'd15); send(4'd15); send(4'd15); send(4'd15);
        chk_result("t2", 60, 0, SUM5_T2, 1);
        tick();

        // 3: backpressure; offered operands in DONE must be ignored
        out_ready = 1'b0;
        send(4'd1); send(4'd2); send(4'd3); send(4'd4);
        in_valid = 1'b1;
        in_data  = 4'd9;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid",    32'(out_valid), 1);
            chk("t3_hold_sum",      32'(out_sum),   10);
            chk("t3_hold_ovf5",     32'(out_ovf5),  0);
            chk("t3_hold_in_ready", 32'(in_ready),  0);
            tick();
        end
        chk_result("t3", 10, 0, 10, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t3_released", 32'(out_valid), 0);
        tick();
        chk("t3_single_xfer", 32'(out_valid), 0);
        chk("t3_idle_ready",  32'(in_ready),  1);

        // 4: gapped input 2,x,x,4,x,6,8
        send(4'd2);
        tick(); tick();
        send(4'd4);
        tick();
        send(4'd6);
        chk("t4_no_extra_beats", 32'(out_valid), 0);
        send(4'd8);
        chk_result("t4", 20, 0, 20, 0);
        tick();

        // 5: clr after 9,9 with a concurrent offered operand
        send(4'd9); send(4'd9);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd7;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("t5_clr_valid",    32'(out_valid), 0);
        chk("t5_clr_in_ready", 32'(in_ready),  1);
        send(4'd1); send(4'd1); send(4'd1);
        chk("t5_not_done_yet", 32'(out_valid), 0);
        send(4'd1);
        chk_result("t5", 4, 0, 4, 0);
        tick();

        // 6: async rst mid-ACCUM, then full batch of 8s
        send(4'd8); send(4'd8);
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_accum_valid", 32'(out_valid), 0);
        chk("t6_rst_accum_ready", 32'(in_ready),  1);
        #2 rst = 1'b0;
        tick();
        out_ready = 1'b0;
        send(4'd8); send(4'd8); send(4'd8); send(4'd8);
        chk_result("t6", 32, 0, SUM5_T6, 1);
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_done_valid", 32'(out_valid), 0);
        chk("t6_rst_done_sum",   32'(out_sum),   0);
        chk("t6_rst_done_ovf5",  32'(out_ovf5),  0);
        chk("t6_rst_done_ready", 32'(in_ready),  1);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
